// File: rtl/alu_result_stage.sv
// alu_result_stage: two-entry result/op FIFO behind the ALU, with the architectural NZC flags register and jump-condition decode
module alu_result_stage #(
  parameter int WIDTH = 8,
  parameter int OPW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carry,
  input  logic             in_zero,
  input  logic             in_negative,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_flag_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic [2:0]       flags,
  input  logic [2:0]       jcond,
  output logic             jtaken
);
  logic [WIDTH-1:0] res_q [2];
  logic [OPW-1:0]   op_q [2];
  logic             wp, rp, push, pop;
  logic [1:0]       count;
  assign in_ready   = count != 2'd2;
  assign out_valid  = count != 2'd0;
  assign push       = in_valid & in_ready;
  assign pop        = out_valid & out_ready;
  assign out_result = res_q[rp];
  assign out_op     = op_q[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
      flags <= 3'b000;
    end else begin
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      if (push && in_flag_we) flags <= {in_negative, in_zero, in_carry};
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
  // Entry storage is not reset; count alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      res_q[wp] <= in_result;
      op_q[wp]  <= in_op;
    end
  end
  always_comb begin
    jtaken = 1'b0;
    case (jcond)
      3'd0: jtaken = 1'b1;
      3'd1: jtaken = flags[1];
      3'd2: jtaken = ~flags[1];
      3'd3: jtaken = flags[0];
      3'd4: jtaken = ~flags[0];
      3'd5: jtaken = flags[2];
      3'd6: jtaken = ~flags[2];
      default: jtaken = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed and random checks of alu_result_stage against a queue-based model
module tb_alu_result_stage;
  logic       clk = 0, reset, in_valid, in_ready, in_carry, in_zero, in_negative, in_flag_we;
  logic       out_valid, out_ready, jtaken;
  logic [7:0] in_result, out_result;
  logic [4:0] in_op, out_op;
  logic [2:0] flags, jcond;
  int total = 0, bad = 0;
  logic [12:0] q[$];
  logic [7:0]  got[$];
  logic [2:0]  mflags = 3'b000;
  logic [7:0]  jexp;
  logic        acc;

  alu_result_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero),
    .in_negative(in_negative), .in_op(in_op), .in_flag_we(in_flag_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_op(out_op), .flags(flags), .jcond(jcond), .jtaken(jtaken)
  );

  always #5 clk = ~clk;

  function automatic logic jref(input logic [2:0] f, input logic [2:0] c);
    logic n, z, cy;
    {n, z, cy} = f;
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("m_in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("m_out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      check("m_out_result", 32'(out_result), 32'(q[0][7:0]));
      check("m_out_op", 32'(out_op), 32'(q[0][12:8]));
    end
    check("m_flags", 32'(flags), 32'(mflags));
    check("m_jtaken", 32'(jtaken), 32'(jref(mflags, jcond)));
  endtask

  task automatic tick();
    bit pu, po;
    pu = in_valid && q.size() < 2;
    po = out_ready && q.size() > 0;
    if (out_valid && out_ready) got.push_back(out_result);
    @(posedge clk);
    if (reset) begin
      q.delete();
      mflags = 3'b000;
    end else begin
      if (po) void'(q.pop_front());
      if (pu) begin
        q.push_back({in_op, in_result});
        if (in_flag_we) mflags = {in_negative, in_zero, in_carry};
      end
    end
    #1;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_result = 0; in_op = 0; in_carry = 0; in_zero = 0;
    in_negative = 0; in_flag_we = 0; out_ready = 0; jcond = 0;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_flags", 32'(flags), 0);
    jexp = 8'b0101_0101;
    for (int j = 0; j < 8; j++) begin
      jcond = 3'(j); #1;
      check($sformatf("rst_jt%0d", j), 32'(jtaken), 32'(jexp[j]));
    end

    in_valid = 1; in_result = 8'h80; in_op = 5'd3; in_negative = 1; in_zero = 0; in_carry = 1;
    in_flag_we = 1; out_ready = 1;
    tick();
    in_valid = 0; jcond = 3'd5; #1;
    check("single_valid", 32'(out_valid), 1);
    check("single_result", 32'(out_result), 32'h80);
    check("single_op", 32'(out_op), 3);
    check("single_flags", 32'(flags), 32'b101);
    check("single_jt5", 32'(jtaken), 1);
    check_model();
    tick();
    check("single_empty", 32'(out_valid), 0);

    out_ready = 0; in_flag_we = 0; in_valid = 1; in_result = 8'h11;
    tick(); check_model();
    in_result = 8'h22;
    tick(); check_model();
    check("bp_full", 32'(in_ready), 0);
    in_result = 8'h33;
    tick(); check_model();
    check("bp_held", 32'(in_ready), 0);
    check("bp_head", 32'(out_result), 32'h11);
    got.delete();
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      acc = in_valid && in_ready;
      tick(); check_model();
      if (acc) in_valid = 0;
    end
    check("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      check("bp_ord0", 32'(got[0]), 32'h11);
      check("bp_ord1", 32'(got[1]), 32'h22);
      check("bp_ord2", 32'(got[2]), 32'h33);
    end

    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      in_result = 8'(i); in_op = 5'($urandom);
      check("st_in_ready", 32'(in_ready), 1);
      tick();
      check("st_valid", 32'(out_valid), 1);
      check("st_result", 32'(out_result), 32'(i));
      check_model();
    end
    in_valid = 0;
    tick(); check_model();

    in_valid = 1; in_flag_we = 1; in_zero = 1; in_negative = 0; in_carry = 0;
    tick();
    in_zero = 0; in_flag_we = 0;
    tick();
    in_valid = 0; jcond = 3'd1; #1;
    check("we_z", 32'(flags[1]), 1);
    check("we_jt1", 32'(jtaken), 1);
    jcond = 3'd2; #1;
    check("we_jt2", 32'(jtaken), 0);
    check_model();

    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0); in_result = 8'($urandom); in_op = 5'($urandom);
        {in_negative, in_zero, in_carry} = 3'($urandom); in_flag_we = 1'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      jcond = 3'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      tick();
      reset = 0; #1;
      check_model();
    end

    in_valid = 0; out_ready = 1;
    tick(); tick();
    out_ready = 0; in_valid = 1; in_flag_we = 1; {in_negative, in_zero, in_carry} = 3'b111;
    in_result = 8'hA1; tick();
    in_result = 8'hB2; tick();
    check("mr_flags", 32'(flags), 32'b111);
    check("mr_full", 32'(in_ready), 0);
    reset = 1; in_result = 8'h5A;
    tick();
    reset = 0; in_valid = 0; #1;
    check("mr_valid", 32'(out_valid), 0);
    check("mr_flags0", 32'(flags), 0);
    check("mr_ready", 32'(in_ready), 1);
    out_ready = 1;
    tick();
    check("mr_nostore", 32'(out_valid), 0);
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered output stage directly downstream of the 8-bit ALU. It accepts the combinational ALU result, its NZC flags and the 5-bit ALU op through a valid/ready handshake. It buffers up to two beats for the register-file/bus writeback and holds the architectural NZC flags register. It also evaluates jump conditions against that register for the control unit.

## Interface
Parameters:
- `WIDTH`, default 8: result width; must match the ALU data width.
- `OPW`, default 5: ALU op field width.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `reset`: input, 1 bit. Synchronous reset, active-high.
- `in_valid`: input, 1 bit. An ALU beat is presented.
- `in_ready`: output, 1 bit. The stage can accept a beat.
- `in_result`: input, `WIDTH` bits. ALU result.
- `in_carry`, `in_zero`, `in_negative`: input, 1 bit each. ALU flags for this beat.
- `in_op`: input, `OPW` bits. ALU op that produced the beat.
- `in_flag_we`: input, 1 bit. This beat updates the flags register.
- `out_valid`: output, 1 bit. The head entry is valid.
- `out_ready`: input, 1 bit. The consumer takes the head entry.
- `out_result`: output, `WIDTH` bits. Head entry result.
- `out_op`: output, `OPW` bits. Head entry op.
- `flags`: output, 3 bits. Registered flags {N,Z,C}.
- `jcond`: input, 3 bits. Jump condition select.
- `jtaken`: output, 1 bit. Combinational condition result computed from `flags`.

## Operation
- Storage is a 2-entry FIFO: entries hold {result, op}, with a write pointer, a read pointer and a 2-bit count (0..2).
- `in_ready` = (count != 2). It is registered-derived, with no combinational path from `out_ready`.
- `out_valid` = (count != 0). `out_result` and `out_op` show the head entry; they are undefined when `out_valid` = 0.
- Push when `in_valid & in_ready`. Pop when `out_valid & out_ready`.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at count 1. At count 2 no push occurs, so a pop alone drops count to 1.
- Pointers are 1 bit each and wrap naturally from 1 to 0.
- Flags update at acceptance, not at pop: on a push with `in_flag_we` = 1, `flags` <= {in_negative, in_zero, in_carry` }` on that edge.
  - A push with `in_flag_we` = 0 leaves `flags` unchanged.
  - A non-accepted beat (in_ready = 0) never touches `flags`.
- `jtaken` decode of `jcond`:
  - 0: always (1).
  - 1: Z.
  - 2: !Z.
  - 3: C.
  - 4: !C.
  - 5: N.
  - 6: !N.
  - 7: never (0).
- The stage does not recompute or check flags. It trusts the ALU values, including the zero/negative values for all 32 ops.

## Timing
- Reset: count = 0, both pointers = 0, `flags` = 3'b000.
  - Outputs after reset: `out_valid` = 0, `in_ready` = 1, `jtaken` = 1 only for jcond 0.
  - FIFO entry contents are not reset.
- Reset during operation discards buffered entries on that edge; a push or pop in the reset cycle is ignored.
- Latency: a beat accepted at edge k appears at `out_*` with `out_valid` = 1 in cycle k+1.
  - This holds when the FIFO was empty, or behind older entries otherwise.
  - There is no bypass path.
- Throughput is 1 beat/cycle when the consumer holds `out_ready` = 1 continuously.
- The flags change visibly in the cycle after the accepting edge. `jtaken` follows in the same cycle as `flags`.
- Upstream must hold `in_*` stable while `in_valid` = 1 and `in_ready` = 0. The stage does not sample in that case.

## Test plan
- Reset, then idle: `out_valid` = 0, `in_ready` = 1, `flags` = 000. Sweep `jcond` 0..7 and check `jtaken` = 1,0,1,0,1,0,1,0.
- Single beat: push result 8'h80, op 5'd3, N=1 Z=0 C=1, we=1, with `out_ready` = 1. Next cycle: `out_result` = 80, `out_op` = 3, `flags` = 101, jcond 5 → `jtaken` = 1. One cycle later: `out_valid` = 0.
- Backpressure: hold `out_ready` = 0 and push results 11, 22, 33. After two pushes `in_ready` = 0 and 33 is held. Release `out_ready` and check output order 11, 22, 33 with no loss or duplication.
- Streaming: 256 consecutive beats (results 00..FF) with both sides always ready. Check one output per cycle in order and `in_ready` constantly 1.
- Flag write-enable: push Z=1 with we=1, then push Z=0 with we=0. Check `flags` Z stays 1, and jcond 1 → 1, jcond 2 → 0.
- Mid-operation reset: with 2 entries buffered and `flags` = 111, assert `reset` for one cycle together with `in_valid`. Next cycle: count 0, `out_valid` = 0, `flags` = 000, and the concurrent beat is not stored.
